mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 74 +++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a fetch port and a data port onto one single-cycle-latency SRAM port.
// Ports: clk, reset_n (async active-low); fetch side f_req/f_addr/f_flush -> f_gnt/f_rvalid/f_rdata;
// data side d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt/d_rvalid/d_rdata;
// SRAM side sram_req/we/addr/wdata/wstrb out, sram_ready/sram_valid/sram_data in; protocol_err sticky flag.
// Optional macro ARB_STARVE_GUARD_EN adds a fetch starvation counter that forces a fetch grant
// after STARVE_LIMIT consecutive denials; without it data always wins over fetch.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    f_req,
  input  logic [ADDR_WIDTH-1:0]   f_addr,
  input  logic                    f_flush,
  output logic                    f_gnt,
  output logic                    f_rvalid,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    sram_req,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_wstrb,
  input  logic                    sram_ready,
  input  logic                    sram_valid,
  input  logic [DATA_WIDTH-1:0]   sram_data,
  output logic                    protocol_err
);
  typedef enum logic [1:0] {NONE, FETCH, DATA} owner_t;
  owner_t owner;
  logic go, fetch_pri;
  // Grants are combinational, so gate them with reset to keep the SRAM quiet while held in reset.
  assign go = reset_n & sram_ready;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  assign fetch_pri = (starve_cnt == CW'(STARVE_LIMIT)) & f_req & ~f_flush;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) starve_cnt <= '0;
    else if (f_gnt || !f_req) starve_cnt <= '0;
    else if (sram_ready && !f_flush && starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
`else
  assign fetch_pri = 1'b0;
`endif
  assign d_gnt      = go & d_req & ~fetch_pri;
  assign f_gnt      = go & f_req & ~f_flush & ~d_gnt;
  assign sram_req   = f_gnt | d_gnt;
  assign sram_we    = d_gnt & d_we;
  assign sram_addr  = d_gnt ? d_addr : f_gnt ? f_addr : '0;
  assign sram_wdata = d_gnt ? d_wdata : '0;
  assign sram_wstrb = d_gnt ? d_wstrb : '0;
  assign f_rdata    = sram_data;
  assign d_rdata    = sram_data;
  // A flush in the response cycle drops the fetch response.
  assign f_rvalid   = (owner == FETCH) & sram_valid & ~f_flush;
  assign d_rvalid   = (owner == DATA) & sram_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      owner        <= NONE;
      protocol_err <= 1'b0;
    end else begin
      owner        <= d_gnt ? DATA : f_gnt ? FETCH : NONE;
      protocol_err <= protocol_err | (sram_valid & (owner == NONE));
    end
endmodule
